// File: rtl/vga_pkg.sv
// Shared definitions for the VGA / CPU video-RAM arbiter: framebuffer
// geometry, RAM-port owner tags, CPU FSM states and colour expansion.
package vga_pkg;

  localparam int FB_W     = 320;          // stored pixels per line
  localparam int FB_H     = 240;          // stored lines
  localparam int ADDR_W   = 17;           // VRAM word-address width
  localparam int PIX_W    = 12;           // RGB 4:4:4
  localparam int FB_WORDS = FB_W * FB_H;  // first out-of-range word address

  // Who issued the RAM read whose data is coming back.
  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_VGA,
    TAG_CPU
  } owner_tag_e;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } cpu_state_e;

  // Replicate each 4-bit channel into 8 bits: {r,r,g,g,b,b}.
  function automatic logic [23:0] expand_rgb444(input logic [PIX_W-1:0] pix);
    return {pix[11:8], pix[11:8], pix[7:4], pix[7:4], pix[3:0], pix[3:0]};
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Generic N-stage, W-bit shift register used to carry the VGA timing
// signals alongside the RAM fetch so they stay aligned with the pixel data.
module vga_sync_delay #(
  parameter int N = 3,
  parameter int W = 1
) (
  input  logic         pclk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [N];

  // Shift one stage per pixel clock; all stages clear on reset.
  always_ff @(posedge pclk) begin
    if (reset) begin
      // NOTE: every stage is cleared, not only the last one, so no stale sync
      // level can emerge in the cycles after reset; this is a short register
      // chain, not a RAM, so resetting it is cheap and deterministic.
      for (int i = 0; i < N; i++) stage_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value; blocking ones would collapse the chain into one.
      stage_q[0] <= d_i;
      for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[N-1];

endmodule

// File: rtl/vga_vram_arb.sv
// Shares one single-port synchronous VRAM between VGA scan-out and a CPU bus.
// Even active pixels belong to VGA; every other cycle is offered to the CPU.
// A two-stage owner-tag pipeline routes returning read data.
module vga_vram_arb
  import vga_pkg::*;
(
  input  logic              pclk,
  input  logic              reset,
  input  logic [9:0]        h_addr,
  input  logic [9:0]        v_addr,
  input  logic              valid,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [23:0]       vga_data,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              valid_out,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [PIX_W-1:0]  cpu_wdata,
  output logic              cpu_ack,
  output logic [PIX_W-1:0]  cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata
);

  localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_WORDS);

  cpu_state_e        state_q,     state_d;
  owner_tag_e        tag0_q,      tag0_d;
  owner_tag_e        tag1_q;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic              ram_we_q,    ram_we_d;
  logic [PIX_W-1:0]  ram_wdata_q, ram_wdata_d;
  logic              cpu_ack_q,   cpu_ack_d;
  logic [PIX_W-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic [PIX_W-1:0]  pixel_q,     pixel_d;
  logic              rd_oor_q,    rd_oor_d;

  logic              vga_slot;
  logic              cpu_accept;
  logic              cpu_in_range;
  logic [ADDR_W-1:0] v_half;
  logic [ADDR_W-1:0] h_half;
  logic [ADDR_W-1:0] vga_addr;
  logic [2:0]        sync_delayed;

  // Slot decode and framebuffer address: (v/2)*320 + h/2 as shift-add.
  assign vga_slot     = valid && !h_addr[0];
  assign cpu_in_range = cpu_addr < FB_LIMIT;
  assign cpu_accept   = (state_q == IDLE) && !vga_slot && cpu_req && !cpu_ack_q;
  assign v_half       = ADDR_W'(v_addr >> 1);
  assign h_half       = ADDR_W'(h_addr >> 1);
  assign vga_addr     = (v_half << 8) + (v_half << 6) + h_half;

  // Next-state: RAM request issue, CPU FSM and read-data routing by tag.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    tag0_d      = TAG_NONE;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    pixel_d     = pixel_q;
    rd_oor_d    = rd_oor_q;

    if (vga_slot) begin
      ram_addr_d = vga_addr;
      tag0_d     = TAG_VGA;
    end else if (cpu_accept) begin
      if (cpu_we) begin
        cpu_ack_d = 1'b1;
        if (cpu_in_range) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = cpu_addr;
          ram_wdata_d = cpu_wdata;
        end
      end else begin
        state_d  = RD_WAIT;
        tag0_d   = TAG_CPU;
        rd_oor_d = !cpu_in_range;
        if (cpu_in_range) ram_addr_d = cpu_addr;
      end
    end

    case (tag1_q)
      TAG_VGA: pixel_d = ram_rdata;
      TAG_CPU: begin
        cpu_rdata_d = rd_oor_q ? '0 : ram_rdata;
        cpu_ack_d   = 1'b1;
        state_d     = IDLE;
      end
      default: ;
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q     <= IDLE;
      tag0_q      <= TAG_NONE;
      tag1_q      <= TAG_NONE;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      pixel_q     <= '0;
      rd_oor_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag0_q      <= tag0_d;
      tag1_q      <= tag0_q;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      pixel_q     <= pixel_d;
      rd_oor_q    <= rd_oor_d;
    end
  end

  vga_sync_delay #(.N(3), .W(3)) u_sync_delay (
    .pclk  (pclk),
    .reset (reset),
    .d_i   ({hsync_in, vsync_in, valid}),
    .q_o   (sync_delayed)
  );

  assign hsync_out = sync_delayed[2];
  assign vsync_out = sync_delayed[1];
  assign valid_out = sync_delayed[0];
  assign vga_data  = valid_out ? expand_rgb444(pixel_q) : 24'h0;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;

endmodule
